// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int BEAT_W    = 4;
  localparam int MAX_NREQ  = 8;
  localparam int MAX_IDX_W = 3;

  // Callers size-cast the result down to their own NREQ.
  function automatic logic [MAX_NREQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    onehot = {{(MAX_NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_chk.sv
// Protocol checks on the arbiter's write-port outputs.
module fifo_wr_arbiter_chk #(
  parameter int NREQ = 4
) (
  input logic            clk_i,
  input logic            rst_n_i,
  input logic [NREQ-1:0] req_i,
  input logic [NREQ-1:0] ack_i,
  input logic            w_en_i,
  input logic            full_i
);

  a_ack_onehot0: assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(ack_i));
  a_wen_is_ack:  assert property (@(posedge clk_i) disable iff (!rst_n_i) w_en_i == (|ack_i));
  a_no_wr_full:  assert property (@(posedge clk_i) disable iff (!rst_n_i) !(w_en_i && full_i));
  a_ack_has_req: assert property (@(posedge clk_i) disable iff (!rst_n_i) (ack_i & ~req_i) == '0);

endmodule

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last, with wrap.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_i,
  output logic                    valid_o,
  output logic [$clog2(NREQ)-1:0] idx_o
);
  localparam int OW = $clog2(NREQ);

  logic [OW-1:0] cand_s;

  // Scan farthest-first so the nearest set request after last_i wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand_s  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand_s  = OW'((int'(last_i) + k) % NREQ);
      idx_o   = req_i[cand_s] ? cand_s : idx_o;
      valid_o = valid_o | req_i[cand_s];
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port between NREQ requesters,
// with bursts capped at BURST_LEN writes per grant.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   wdata_in,
  input  logic                     full,
  output logic [NREQ-1:0]          ack,
  output logic                     w_en,
  output logic [DATA_W-1:0]        w_data,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);
  localparam int OW = $clog2(NREQ);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  arb_state_t    state_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] last_q;
  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] beat_d;

  logic          pick_valid_s;
  logic [OW-1:0] pick_idx_s;
  logic          grant_s;
  logic          w_en_s;
  logic          exit_s;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .valid_o (pick_valid_s),
    .idx_o   (pick_idx_s)
  );

  // Write port decode; everything is gated by GRANT so reset silences it at once.
  always_comb begin
    grant_s = (state_q == GRANT);
    w_en_s  = grant_s & req[owner_q] & ~full;
    exit_s  = grant_s & (~req[owner_q] | (w_en_s & (beat_q == LAST_BEAT)));
    beat_d  = w_en_s ? (beat_q + 4'd1) : beat_q;
    w_en    = w_en_s;
    ack     = w_en_s ? NREQ'(onehot(MAX_IDX_W'(owner_q))) : '0;
    w_data  = grant_s ? wdata_in[int'(owner_q)*DATA_W +: DATA_W] : '0;
    owner   = owner_q;
    busy    = grant_s;
  end

  // Arbitration FSM: pick in IDLE, count beats in GRANT, record last owner on exit.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NREQ - 1);
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid_s && !full) begin
            owner_q <= pick_idx_s;
            beat_q  <= '0;
            state_q <= GRANT;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (exit_s) begin
            last_q  <= owner_q;
            beat_q  <= '0;
            state_q <= IDLE;
          end else begin
            beat_q  <= beat_d;
          end
        end
        default: begin
          state_q <= IDLE;
          beat_q  <= '0;
        end
      endcase
    end
  end

  fifo_wr_arbiter_chk #(.NREQ(NREQ)) u_chk (
    .clk_i   (wclk),
    .rst_n_i (wrst_n),
    .req_i   (req),
    .ack_i   (ack),
    .w_en_i  (w_en),
    .full_i  (full)
  );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DATA_W=8, BURST_LEN=4).
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req;
  logic [31:0] wdata_in;
  logic        full;
  logic [3:0]  ack;
  logic        w_en;
  logic [7:0]  w_data;
  logic [1:0]  owner;
  logic        busy;

  int nvec = 0;
  int nerr = 0;
  int wcnt;
  logic wr, bz;

  fifo_wr_arbiter #(.NREQ(4), .DATA_W(8), .BURST_LEN(4)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .req      (req),
    .wdata_in (wdata_in),
    .full     (full),
    .ack      (ack),
    .w_en     (w_en),
    .w_data   (w_data),
    .owner    (owner),
    .busy     (busy)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp_cyc(input string tag, input logic e_wen, input logic [3:0] e_ack,
                         input logic [7:0] e_dat, input logic [1:0] e_own, input logic e_bz);
    chk({tag, ".w_en"},   32'(w_en),   32'(e_wen));
    chk({tag, ".ack"},    32'(ack),    32'(e_ack));
    chk({tag, ".w_data"}, 32'(w_data), 32'(e_dat));
    chk({tag, ".owner"},  32'(owner),  32'(e_own));
    chk({tag, ".busy"},   32'(busy),   32'(e_bz));
  endtask

  task automatic tick;
    @(posedge wclk);
    #1;
  endtask

  task automatic pulse_reset;
    tick;
    req    = 4'b0000;
    full   = 1'b0;
    wrst_n = 1'b0;
    #2;
    wrst_n = 1'b1;
  endtask

  initial begin
    wrst_n   = 1'b0;
    req      = 4'b0001;
    full     = 1'b0;
    wdata_in = 32'h4433_2211;
    #12;
    exp_cyc("reset", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
    @(negedge wclk);
    wrst_n = 1'b1;
    req    = 4'b0000;

    // Single requester, 6 words: burst of 4, dead cycle, then 2 more.
    wcnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      req      = (c < 8) ? 4'b0001 : 4'b0000;
      wdata_in = {8'h44, 8'h33, 8'h22, 8'(8'hA0 + wcnt)};
      #1;
      wr = ((c >= 1) && (c <= 4)) || (c == 6) || (c == 7);
      bz = wr || (c == 8);
      exp_cyc($sformatf("single.c%0d", c), wr, wr ? 4'b0001 : 4'b0000,
              bz ? 8'(8'hA0 + wcnt) : 8'h00, 2'd0, bz);
      if (wr) wcnt++;
    end

    // All four requesting: order 0,1,2,3,0 with one dead cycle between bursts.
    pulse_reset;
    wdata_in = 32'h4433_2211;
    for (int b = 0; b < 5; b++) begin
      tick;
      req = 4'b1111;
      #1;
      exp_cyc($sformatf("rr.b%0d.idle", b), 1'b0, 4'b0000, 8'h00,
              2'((b == 0) ? 0 : (b - 1) % 4), 1'b0);
      for (int k = 0; k < 4; k++) begin
        tick;
        #1;
        exp_cyc($sformatf("rr.b%0d.w%0d", b, k), 1'b1, 4'(4'b0001 << (b % 4)),
                8'(17 * ((b % 4) + 1)), 2'(b % 4), 1'b1);
      end
    end
    tick;
    req = 4'b0000;
    #1;
    exp_cyc("rr.end", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);

    // Requester 2, full for 5 cycles after 2 writes; grant and beat count held.
    for (int c = 0; c < 11; c++) begin
      tick;
      req  = (c < 10) ? 4'b0100 : 4'b0000;
      full = (c >= 3) && (c <= 7);
      #1;
      wr = (c == 1) || (c == 2) || (c == 8) || (c == 9);
      bz = (c >= 1) && (c <= 9);
      exp_cyc($sformatf("full.c%0d", c), wr, wr ? 4'b0100 : 4'b0000,
              bz ? 8'h33 : 8'h00, (c == 0) ? 2'd0 : 2'd2, bz);
    end

    // Requester 1 drops after one beat; grant passes to 3.
    pulse_reset;
    tick;
    req = 4'b1010;
    #1;
    exp_cyc("drop.c0", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
    tick;
    #1;
    exp_cyc("drop.c1", 1'b1, 4'b0010, 8'h22, 2'd1, 1'b1);
    tick;
    req = 4'b1000;
    #1;
    exp_cyc("drop.c2", 1'b0, 4'b0000, 8'h22, 2'd1, 1'b1);
    tick;
    #1;
    exp_cyc("drop.c3", 1'b0, 4'b0000, 8'h00, 2'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick;
      #1;
      exp_cyc($sformatf("own3.w%0d", k), 1'b1, 4'b1000, 8'h44, 2'd3, 1'b1);
    end

    // Asynchronous reset mid-burst, then restart from requester 0.
    #1;
    wrst_n = 1'b0;
    #1;
    exp_cyc("mrst.async", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
    tick;
    req = 4'b1001;
    #1;
    exp_cyc("mrst.held", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
    wrst_n = 1'b1;
    #1;
    exp_cyc("mrst.idle", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
    tick;
    #1;
    exp_cyc("mrst.grant0", 1'b1, 4'b0001, 8'h11, 2'd0, 1'b1);
    tick;
    req = 4'b0000;
    #1;
    exp_cyc("mrst.drop", 1'b0, 4'b0000, 8'h11, 2'd0, 1'b1);

    // Full held in IDLE blocks arbitration; release grants requester 1.
    for (int c = 0; c < 3; c++) begin
      tick;
      req  = 4'b0110;
      full = 1'b1;
      #1;
      exp_cyc($sformatf("idlefull.c%0d", c), 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
    end
    tick;
    full = 1'b0;
    #1;
    exp_cyc("idlefull.rel", 1'b0, 4'b0000, 8'h00, 2'd0, 1'b0);
    tick;
    #1;
    exp_cyc("idlefull.grant1", 1'b1, 4'b0010, 8'h22, 2'd1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
